maze_map: RTL
=============

# maze_map

Maze storage and responder for the wall-follower solver. Holds a 2^maze_width × 2^maze_width wall bitmap, loaded in row-major order from a streaming loader, then answers the solver's `row`/`col`/`maze_oe` reads with a registered `maze_in` and records `maze_we` marks in a separate visited bitmap. It sits between the testbench/loader and the solver. It also exposes a visited-cell count, a sticky error flag and a debug readback port for verification.

## Interface
- `maze_width`, 6, index bits per axis; map is 2^maze_width square.
- `load_w`, 8, cells per loader word; must divide 2^maze_width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `load_valid`  in  1  loader word valid.
- `load_data`  in  load_w  wall bits; bit k → column `col_ptr + k`; 1 = wall, 0 = path.
- `load_ready`  out  1  high exactly in LOAD.
- `reload`  in  1  single-cycle pulse; restarts loading from cell (0,0).
- `row`, `col`  in  maze_width  solver cell select.
- `maze_oe`  in  1  solver read enable, sampled at clock edge.
- `maze_we`  in  1  solver mark-visited enable, sampled at clock edge.
- `done`  in  1  solver finished; freezes the map.
- `maze_in`  out  1  registered wall bit of last read cell.
- `map_ready`  out  1  high in SERVE and HOLD.
- `visit_count`  out  2*maze_width+1  number of distinct cells marked visited.
- `bad_write`  out  1  sticky; set when `maze_we` targets a wall cell.
- `dbg_row`, `dbg_col`  in  maze_width  debug readback select.
- `dbg_data`  out  2  {visited, wall} of debug cell, registered.

## Operation
- States: LOAD, SERVE, HOLD.
- LOAD: accept word when `load_valid && load_ready`. Write `load_w` wall bits at (`row_ptr`, `col_ptr`…`col_ptr+load_w-1`). Clear the same visited bits. Advance `col_ptr` by `load_w`; on wrap to 0, increment `row_ptr`. The word filling cell (2^mw−1, 2^mw−1) moves the FSM to SERVE. `maze_oe`/`maze_we` are ignored and `maze_in` holds 1.
- SERVE: `maze_oe` → `maze_in <= wall[row][col]`; otherwise `maze_in` holds. `maze_we` → `visited[row][col] <= 1`. `visit_count` increments only if the bit was previously 0. If `wall[row][col]`=1, set `bad_write`; the visited bit is still set. `done`=1 → HOLD.
- HOLD: reads still served; `maze_we` ignored; `visit_count` and visited bitmap frozen.
- `reload` in any state → LOAD, pointers 0, `visit_count` 0, `bad_write` 0, `maze_in` 1. `reload` has priority over all other inputs that cycle.
- Indices are naturally modulo 2^maze_width; no out-of-range case exists. Row −1 from the solver reads row 2^mw−1.
- Debug port is always active: `dbg_data <= {visited, wall}[dbg_row][dbg_col]` every cycle, in every state.

## Timing
- Reset (`rst_n`=0 at edge): state LOAD, `row_ptr`=`col_ptr`=0, `maze_in`=1, `visit_count`=0, `bad_write`=0, `dbg_data`=0. `load_ready`=1 from the first cycle after reset. Bitmap contents are undefined until loaded.
- Read latency: 1 cycle. `maze_oe` with row/col at edge N gives valid `maze_in` after edge N, for the solver's following check cycle.
- `maze_oe` and `maze_we` at the same edge on the same cell: `maze_in` returns the wall bit; the visited update lands in the same edge. No ordering hazard, since the bitmaps are separate.
- Repeated `maze_we` on a visited cell leaves `visit_count` unchanged.
- Full load takes 2^(2·mw)/load_w accepted words: 512 at defaults. `map_ready` rises the cycle after the last accept.
- Stalls: `load_valid`=0 holds pointers. Accepts may be back-to-back, one word per cycle.
- `done` and `maze_we` at the same edge in SERVE: the write is applied, then the FSM enters HOLD.
- Reset or `reload` mid-load: the partial map is discarded; loading restarts at (0,0).

## Structure
- Shared package `maze_pkg`: state encoding (LOAD/SERVE/HOLD), `maze_width` default, and the wall/path bit meaning (1 = wall). The solver reuses the package.
- One sub-module is natural: `maze_bitmap`, a 1-write/2-read bit RAM. Instantiate it twice, once for walls and once for visited. The visited instance needs a word-wide write for load-time clearing.

## Test plan
- Reset, then load an all-wall map with a single path row 5 (cols 0..63 = 0) → `map_ready` rises after word 512; `load_ready` drops in the same cycle.
- After load, `maze_oe` at (5,10) → `maze_in`=0 next cycle; `maze_oe` at (4,10) → `maze_in`=1.
- `maze_we` at (5,10) twice, then at (5,11) → `visit_count`=2; `dbg_data` at (5,10) = 2'b10.
- `maze_we` at wall (0,0) → `bad_write`=1, stays 1 through subsequent clean writes.
- `done`=1, then `maze_we` at (5,12) → `visit_count` stays 2; reads at (5,12) still return 0.
- `reload` mid-load after 100 words, then stall `load_valid` 3 cycles, then a full reload → `visit_count`=0, `bad_write`=0, map reflects only the new data.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze storage block and the wall-follower solver.
package maze_pkg;

    // Index bits per axis; the map is 2^MAZE_WIDTH cells on a side.
    localparam int MAZE_WIDTH = 6;

    // Cells carried by one loader word; must divide 2^MAZE_WIDTH.
    localparam int LOAD_W = 8;

    // Wall bitmap meaning: 1 = wall, 0 = open path.
    localparam logic WALL = 1'b1;

    // Map life cycle: streaming load, serving the solver, frozen after done.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_HOLD  = 2'd2
    } maze_state_t;

endpackage

// File: rtl/maze_bitmap.sv
// Word-organised bit RAM: one masked word write port, two asynchronous read
// ports. The owner registers whatever it reads out.
module maze_bitmap #(
    parameter int aw = 9,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [dw-1:0] wdata,
    input  logic [dw-1:0] wmask,
    input  logic [aw-1:0] raddr_a,
    output logic [dw-1:0] rdata_a,
    input  logic [aw-1:0] raddr_b,
    output logic [dw-1:0] rdata_b
);

    logic [dw-1:0] mem [2**aw];

    // Masked write: only bits set in wmask take wdata, the rest keep their value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/maze_map.sv
// Maze storage and responder: streams in the wall map, serves solver reads,
// records visited cells and offers a debug readback port.
//
// Loader handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high; load_ready is high exactly while loading, and the
// loader may hold load_valid low for any number of cycles without losing place.
module maze_map
    import maze_pkg::*;
#(
    parameter int maze_width = MAZE_WIDTH,
    parameter int load_w     = LOAD_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [load_w-1:0]       load_data,
    output logic                    load_ready,
    input  logic                    reload,
    input  logic [maze_width-1:0]   row,
    input  logic [maze_width-1:0]   col,
    input  logic                    maze_oe,
    input  logic                    maze_we,
    input  logic                    done,
    output logic                    maze_in,
    output logic                    map_ready,
    output logic [2*maze_width:0]   visit_count,
    output logic                    bad_write,
    input  logic [maze_width-1:0]   dbg_row,
    input  logic [maze_width-1:0]   dbg_col,
    output logic [1:0]              dbg_data,
    output maze_state_t             fsm_state
);

    // Column bits split into word select (upper) and bit-in-word (lower).
    localparam int LB = $clog2(load_w);
    localparam int AW = 2*maze_width - LB;
    localparam logic [maze_width-1:0] COL_STEP = maze_width'(load_w);
    localparam logic [maze_width-1:0] COL_LAST = maze_width'((1 << maze_width) - load_w);
    localparam logic [maze_width-1:0] ROW_LAST = '1;

    maze_state_t           state;
    logic [maze_width-1:0] row_ptr;
    logic [maze_width-1:0] col_ptr;

    logic [AW-1:0]     load_addr, cell_addr, dbg_addr;
    logic [load_w-1:0] wall_cell_w, vis_cell_w, wall_dbg_w, vis_dbg_w;
    logic [load_w-1:0] cell_onehot;
    logic              wall_bit, vis_bit;
    logic              accept, mark;
    logic              vis_we;
    logic [AW-1:0]     vis_waddr;
    logic [load_w-1:0] vis_wdata, vis_wmask;

    assign load_addr   = {row_ptr, col_ptr[maze_width-1:LB]};
    assign cell_addr   = {row, col[maze_width-1:LB]};
    assign dbg_addr    = {dbg_row, dbg_col[maze_width-1:LB]};
    assign cell_onehot = load_w'(1) << col[LB-1:0];
    assign wall_bit    = wall_cell_w[col[LB-1:0]];
    assign vis_bit     = vis_cell_w[col[LB-1:0]];

    // Reset and reload win over every other input, so they block both writes.
    assign accept = rst_n && !reload && (state == ST_LOAD) && load_valid;
    assign mark   = rst_n && !reload && (state == ST_SERVE) && maze_we;

    // The visited map is cleared word-wide while loading, bit-wise set while serving.
    assign vis_we    = accept || mark;
    assign vis_waddr = accept ? load_addr : cell_addr;
    assign vis_wdata = accept ? '0 : '1;
    assign vis_wmask = accept ? '1 : cell_onehot;

    assign fsm_state = state;

    maze_bitmap #(.aw(AW), .dw(load_w)) u_wall (
        .clk     (clk),
        .we      (accept),
        .waddr   (load_addr),
        .wdata   (load_data),
        .wmask   ('1),
        .raddr_a (cell_addr),
        .rdata_a (wall_cell_w),
        .raddr_b (dbg_addr),
        .rdata_b (wall_dbg_w)
    );

    maze_bitmap #(.aw(AW), .dw(load_w)) u_visited (
        .clk     (clk),
        .we      (vis_we),
        .waddr   (vis_waddr),
        .wdata   (vis_wdata),
        .wmask   (vis_wmask),
        .raddr_a (cell_addr),
        .rdata_a (vis_cell_w),
        .raddr_b (dbg_addr),
        .rdata_b (vis_dbg_w)
    );

    // Control FSM: load pointers, solver responses, visit counting and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n || reload) begin
            state       <= ST_LOAD;
            row_ptr     <= '0;
            col_ptr     <= '0;
            maze_in     <= WALL;
            visit_count <= '0;
            bad_write   <= 1'b0;
            load_ready  <= 1'b1;
            map_ready   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_valid) begin
                        col_ptr <= col_ptr + COL_STEP;
                        if (col_ptr == COL_LAST) begin
                            row_ptr <= row_ptr + 1'b1;
                            if (row_ptr == ROW_LAST) begin
                                state      <= ST_SERVE;
                                load_ready <= 1'b0;
                                map_ready  <= 1'b1;
                            end
                        end
                    end
                end
                ST_SERVE: begin
                    if (maze_oe) begin
                        maze_in <= wall_bit;
                    end
                    if (maze_we) begin
                        if (!vis_bit) begin
                            visit_count <= visit_count + 1'b1;
                        end
                        if (wall_bit == WALL) begin
                            bad_write <= 1'b1;
                        end
                    end
                    if (done) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (maze_oe) begin
                        maze_in <= wall_bit;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // Debug readback runs every cycle regardless of state; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_data <= 2'b00;
        end else begin
            dbg_data <= {vis_dbg_w[dbg_col[LB-1:0]], wall_dbg_w[dbg_col[LB-1:0]]};
        end
    end

endmodule
